// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and helpers, used by the sync generator
// and by the figure renderers that consume HCount/VCount.
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int          CNT_W       = 10;
  localparam logic        SYNC_ACTIVE = 1'b0;
  localparam logic [2:0]  RGB_BLANK   = 3'b000;

  function automatic logic in_window(input logic [CNT_W-1:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) <= hi);
  endfunction

endpackage

// File: rtl/vga_counter.sv
// Modulo-N position counter with enable; wrap_o strobes on the enabled
// cycle that takes the count back to zero.
module vga_counter #(
  parameter int MODULUS = 800,
  parameter int W       = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] count_q, count_d;
  logic         at_end;

  // ">=" so an out-of-range value also falls back to zero on the next enable
  assign at_end = (count_q >= LAST);
  assign wrap_o = en_i & at_end;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = at_end ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate divider, H/V position counters and
// registered, blanked sync/colour outputs one pixel behind the counters.
module vga_sync_gen #(
  parameter int H_VISIBLE = vga_timing_pkg::VGA_H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::VGA_H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::VGA_H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::VGA_H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::VGA_V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::VGA_V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::VGA_V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::VGA_V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] HCount,
  output logic [9:0] VCount,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb_out
);

  import vga_timing_pkg::*;

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  logic             div_q, div_d;
  logic             h_wrap, v_wrap;
  logic [CNT_W-1:0] h_count, v_count;
  logic             hsync_raw, vsync_raw;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [2:0]       rgb_q, rgb_d;

  assign div_d      = ~div_q;
  assign pixel_tick = div_q;

  vga_counter #(.MODULUS(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (pixel_tick),
    .count_o (h_count),
    .wrap_o  (h_wrap)
  );

  vga_counter #(.MODULUS(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (h_wrap),
    .count_o (v_count),
    .wrap_o  (v_wrap)
  );

  // v_wrap can only fire on an h_wrap, which itself only fires on pixel_tick
  assign frame_start = v_wrap;

  assign video_on  = (h_count < CNT_W'(H_VISIBLE)) && (v_count < CNT_W'(V_VISIBLE));
  assign hsync_raw = in_window(h_count, H_SYNC_START, H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync_raw = in_window(v_count, V_SYNC_START, V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (pixel_tick) begin
      hsync_d = hsync_raw;
      vsync_d = vsync_raw;
      rgb_d   = video_on ? rgb_in : RGB_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= 1'b0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      rgb_q   <= RGB_BLANK;
    end else begin
      div_q   <= div_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign HCount  = h_count;
  assign VCount  = v_count;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign rgb_out = rgb_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with full horizontal timing and a shortened frame
// (15 lines, vsync on lines 10..11) so two frames fit in a short run.
module tb_vga_sync_gen;

  localparam int HT   = 800;
  localparam int VT   = 15;
  localparam int FR   = HT * VT;
  localparam int VVIS = 8;
  localparam int NVEC = 17;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] rgb_in;
  logic [9:0] HCount, VCount;
  logic       video_on, pixel_tick, frame_start, hsync, vsync;
  logic [2:0] rgb_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tbl_idx = 0;
  bit stats_on = 1'b0;
  int fs_count = 0, fs_first = -1, fs_last = -1, fs_gap = -1;
  int hs_low = 0, vs_low = 0, rgb7 = 0;

  typedef struct {
    int         c;
    logic       pt, fs, von, hs, vs;
    logic [9:0] h, v;
    logic [2:0] rgb;
  } vec_t;

  vec_t tbl [NVEC];

  vga_sync_gen #(
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rgb_in      (rgb_in),
    .HCount      (HCount),
    .VCount      (VCount),
    .video_on    (video_on),
    .pixel_tick  (pixel_tick),
    .frame_start (frame_start),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb_out     (rgb_out)
  );

  always #10 clk = ~clk;

  // colour presented for raster position t (ticks since reset release)
  function automatic logic [2:0] fn(input int t);
    int p, h, v;
    p = t % FR;
    h = p % HT;
    v = p / HT;
    if (t / FR == 0) return 3'b111;
    return 3'((h ^ v) & 7);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    int t, p, h, v, q, hq, vq;
    logic pt, fs, von, hs, vs;
    logic [2:0] rgb;
    t   = cyc / 2;
    pt  = (cyc % 2) == 1;
    p   = t % FR;
    h   = p % HT;
    v   = p / HT;
    von = (h < 640) && (v < VVIS);
    fs  = pt && (p == FR - 1);
    if (t == 0) begin
      hs = 1'b1; vs = 1'b1; rgb = 3'b000;
    end else begin
      q   = (t - 1) % FR;
      hq  = q % HT;
      vq  = q / HT;
      hs  = !(hq >= 656 && hq <= 751);
      vs  = !(vq >= 10 && vq <= 11);
      rgb = (hq < 640 && vq < VVIS) ? fn(t - 1) : 3'b000;
    end
    chk("pixel_tick",  32'(pixel_tick),  32'(pt));
    chk("HCount",      32'(HCount),      32'(h));
    chk("VCount",      32'(VCount),      32'(v));
    chk("video_on",    32'(video_on),    32'(von));
    chk("frame_start", 32'(frame_start), 32'(fs));
    chk("hsync",       32'(hsync),       32'(hs));
    chk("vsync",       32'(vsync),       32'(vs));
    chk("rgb_out",     32'(rgb_out),     32'(rgb));

    if (tbl_idx < NVEC && tbl[tbl_idx].c == cyc) begin
      chk("tbl.pixel_tick",  32'(pixel_tick),  32'(tbl[tbl_idx].pt));
      chk("tbl.frame_start", 32'(frame_start), 32'(tbl[tbl_idx].fs));
      chk("tbl.video_on",    32'(video_on),    32'(tbl[tbl_idx].von));
      chk("tbl.hsync",       32'(hsync),       32'(tbl[tbl_idx].hs));
      chk("tbl.vsync",       32'(vsync),       32'(tbl[tbl_idx].vs));
      chk("tbl.HCount",      32'(HCount),      32'(tbl[tbl_idx].h));
      chk("tbl.VCount",      32'(VCount),      32'(tbl[tbl_idx].v));
      chk("tbl.rgb_out",     32'(rgb_out),     32'(tbl[tbl_idx].rgb));
      tbl_idx++;
    end

    if (stats_on) begin
      if (cyc <= 1600 && hsync === 1'b0) hs_low++;
      if (cyc <= 24000 && vsync === 1'b0) vs_low++;
      if (cyc <= 24000 && rgb_out === 3'b111) rgb7++;
      if (frame_start === 1'b1) begin
        fs_count++;
        if (fs_count == 1) fs_first = cyc;
        else fs_gap = cyc - fs_last;
        fs_last = cyc;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    model_check();
    rgb_in = fn(cyc / 2);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".HCount"},      32'(HCount),      32'd0);
    chk({tag, ".VCount"},      32'(VCount),      32'd0);
    chk({tag, ".hsync"},       32'(hsync),       32'd1);
    chk({tag, ".vsync"},       32'(vsync),       32'd1);
    chk({tag, ".rgb_out"},     32'(rgb_out),     32'd0);
    chk({tag, ".pixel_tick"},  32'(pixel_tick),  32'd0);
    chk({tag, ".frame_start"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    //                c      pt fs von hs vs  H        V       rgb
    tbl[0]  = '{1,     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0,   10'd0,  3'd0};
    tbl[1]  = '{2,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd1,   10'd0,  3'd7};
    tbl[2]  = '{4,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd2,   10'd0,  3'd7};
    tbl[3]  = '{1281,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd640, 10'd0,  3'd7};
    tbl[4]  = '{1282,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd641, 10'd0,  3'd0};
    tbl[5]  = '{1313,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'd656, 10'd0,  3'd0};
    tbl[6]  = '{1314,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd657, 10'd0,  3'd0};
    tbl[7]  = '{1504,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd752, 10'd0,  3'd0};
    tbl[8]  = '{1506,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd753, 10'd0,  3'd0};
    tbl[9]  = '{1600,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0,   10'd1,  3'd0};
    tbl[10] = '{16000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0,   10'd10, 3'd0};
    tbl[11] = '{16002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd1,   10'd10, 3'd0};
    tbl[12] = '{19200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0,   10'd12, 3'd0};
    tbl[13] = '{19202, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd1,   10'd12, 3'd0};
    tbl[14] = '{23999, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 10'd799, 10'd14, 3'd0};
    tbl[15] = '{24000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0,   10'd0,  3'd0};
    tbl[16] = '{24012, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd6,   10'd0,  3'd5};

    reset  = 1'b1;
    rgb_in = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");

    reset    = 1'b0;
    cyc      = 0;
    stats_on = 1'b1;
    rgb_in   = fn(0);
    repeat (65400) step();

    chk("hsync_low_clks",   32'(hs_low),   32'd192);
    chk("vsync_low_clks",   32'(vs_low),   32'd3200);
    chk("rgb_white_clks",   32'(rgb7),     32'd10240);
    chk("frame_start_cnt",  32'(fs_count), 32'd2);
    chk("frame_start_1st",  32'(fs_first), 32'd23999);
    chk("frame_start_gap",  32'(fs_gap),   32'd24000);
    chk("vectors_applied",  32'(tbl_idx),  32'(NVEC));

    // mid-line, mid-vsync reset: both syncs are low right now
    chk("pre_reset.HCount", 32'(HCount), 32'd700);
    chk("pre_reset.VCount", 32'(VCount), 32'd10);
    chk("pre_reset.hsync",  32'(hsync),  32'd0);
    chk("pre_reset.vsync",  32'(vsync),  32'd0);
    stats_on = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("midreset");

    reset  = 1'b0;
    cyc    = 0;
    rgb_in = fn(0);
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
